pe_stage_sequencer: RTL
=======================

Name: pe_stage_sequencer

Overview:
- Sequences one butterfly stage of the SC polar decoder through a single shared pe_2-style processing element.
- For a stage of 2^log_len LLR pairs, it:
  - generates paired read addresses into the LLR buffer,
  - presents operands, mode and the partial-sum bit to the PE,
  - registers the PE result and writes it back at consecutive output addresses.
- Start/done handshake to the top-level decoder schedule; hold input for write-port back-pressure.

Parameters:
- LLR_W, 9, LLR width (matches PE q1/q2/o1).
- ADDR_W, 8, LLR buffer address width.
- LOG_MAX, 7, largest supported log2(pairs per stage).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch a stage (sampled only in IDLE)
- mode  in  1  0 = f operation, 1 = g operation (latched at start)
- log_len  in  3  log2 of pair count (latched; values >LOG_MAX clamp to LOG_MAX)
- rd_base  in  ADDR_W  first upper-half operand address (latched)
- wr_base  in  ADDR_W  first result address (latched)
- hold  in  1  freeze issue and write-back
- rd_en  out  1  LLR buffer read strobe
- rd_addr_a  out  ADDR_W  rd_base+i
- rd_addr_b  out  ADDR_W  rd_base+i+2^log_len
- u_addr  out  ADDR_W  partial-sum index i
- rd_data_a  in  LLR_W  port A data, valid 1 cycle after rd_en
- rd_data_b  in  LLR_W  port B data, valid 1 cycle after rd_en
- u_data  in  1  partial-sum bit, valid 1 cycle after rd_en
- pe_q1  out  LLR_W  PE operand 1 (= rd_data_a)
- pe_q2  out  LLR_W  PE operand 2 (= rd_data_b)
- pe_mode  out  1  latched mode
- pe_u  out  1  = u_data
- pe_o1  in  LLR_W  PE combinational result
- wr_en  out  1  result write strobe
- wr_addr  out  ADDR_W  wr_base+i
- wr_data  out  LLR_W  registered pe_o1
- busy  out  1  stage in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; FSM to IDLE; pair counter 0.
- rst mid-operation:
  - aborts the stage at once;
  - no further rd_en/wr_en;
  - no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches mode/log_len/rd_base/wr_base, clears i and enters RUN;
  - busy rises the following cycle.
- RUN:
  - Each cycle with hold=0: rd_en=1, addresses from the current i, then i increments.
  - hold=1: rd_en=0 and i is unchanged.
  - After issuing i = 2^log_len-1, go to DRAIN.
- Pipeline: issue (cycle k) -> data/PE (k+1) -> write (k+2). Result latency from rd_en to wr_en is 2 cycles when hold is low.
- Data stage:
  - pe_q1/pe_q2/pe_u are direct wires from read data;
  - pe_o1 is captured into wr_data with its wr_addr;
  - this register and the write stage advance only when hold=0.
- Hold contract:
  - hold=1 forces wr_en=0 and freezes both pipeline stages.
  - The LLR buffer output must stay stable while rd_en=0.
  - On release, the pending write is issued with its original address and data.
- DRAIN:
  - waits until both pipeline stages are empty, i.e. the last write is accepted with hold=0;
  - then goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start in this cycle is ignored.
- start while busy: ignored; latched configuration is unchanged.
- Address arithmetic:
  - modulo 2^ADDR_W; overflow wraps silently;
  - rd_addr_b offset is 2^log_len computed in ADDR_W bits.
- Results are written in ascending i order, exactly 2^log_len writes per stage, with no duplicates.
- log_len=0: a single pair; the stage takes 5 cycles from start to done with no hold.
- Data: the block never alters LLR values; wr_data equals the pe_o1 sampled in the data stage.

Test Plan:
- Reset, then start with mode=0, log_len=2, rd_base=0x10, wr_base=0x40, hold=0:
  - rd_addr_a 0x10..0x13 and rd_addr_b 0x14..0x17 on 4 consecutive rd_en cycles;
  - wr_addr 0x40..0x43 exactly 2 cycles after each;
  - done one cycle after the last write; busy high between start+1 and done.
- mode=1, u_data pattern 1,0,1,1, PE model = sign-magnitude g:
  - pe_mode=1 throughout;
  - pe_u follows the pattern;
  - wr_data matches the model for operands 9'b010001100 / 9'b101010001 loaded at pair 0.
- hold asserted for 3 cycles mid-RUN (after pair 1 issued):
  - no rd_en/wr_en during hold;
  - pending write resumes with unchanged addr/data;
  - total writes = 4, no duplicates; done delayed by 3 cycles.
- log_len=0 and log_len=7 with rd_base=0xF0:
  - 1 write and done at start+5;
  - 128 writes with rd_addr wrapping 0xFF -> 0x00.
- rst asserted on the 3rd RUN cycle:
  - all outputs 0 next cycle, no done, FSM in IDLE;
  - a fresh start then runs a complete stage.
- start pulsed again while busy and in the DONE cycle: ignored; latched configuration and write count are unchanged.

Source files
------------

// File: rtl/pe_stage_sequencer.sv
// pe_stage_sequencer: drives one SC-polar butterfly stage through a shared pe_2-style processing element.
// Latency: start -> first rd_en 2 cycles; rd_en -> wr_en 2 cycles; last write -> done 1 cycle (log_len=0: done at start+5).
// Backpressure: hold=1 gates rd_en/wr_en low and freezes the issue, data and write stages; the pending write resumes unchanged.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, mode, log_len,         stage launch and configuration; sampled only in IDLE
//   rd_base, wr_base
//   hold                          freeze issue and write-back
//   rd_en, rd_addr_a/b, u_addr    LLR buffer read port (registered)
//   rd_data_a/b, u_data           buffer return data, valid one cycle after rd_en
//   pe_q1, pe_q2, pe_u, pe_mode   PE operands (direct wires) and latched mode
//   pe_o1                         PE combinational result
//   wr_en, wr_addr, wr_data       result write port (registered)
//   busy, done                    stage in progress / one-cycle completion pulse
module pe_stage_sequencer #(
  parameter int LLR_W   = 9,
  parameter int ADDR_W  = 8,
  parameter int LOG_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [2:0]        log_len,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] u_addr,
  input  logic [LLR_W-1:0]  rd_data_a,
  input  logic [LLR_W-1:0]  rd_data_b,
  input  logic              u_data,
  output logic [LLR_W-1:0]  pe_q1,
  output logic [LLR_W-1:0]  pe_q2,
  output logic              pe_mode,
  output logic              pe_u,
  input  logic [LLR_W-1:0]  pe_o1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LLR_W-1:0]  wr_data,
  output logic              busy,
  output logic              done
);

  // One extra bit so the pair counter can represent 2^LOG_MAX after the last issue.
  localparam int CNT_W = LOG_MAX + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;

  // Latched stage configuration
  logic              mode_q, mode_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;

  // Pair counter
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Issue stage: the registered read command; u_addr_q doubles as the pair index
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [ADDR_W-1:0] u_addr_q, u_addr_d;

  // Data stage: buffer data is on the wires, only validity and index are tracked
  logic              dat_vld_q, dat_vld_d;
  logic [ADDR_W-1:0] dat_idx_q, dat_idx_d;

  // Write stage
  logic              wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LLR_W-1:0]  wr_data_q, wr_data_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              adv;
  logic [2:0]        len_clamp;
  logic [CNT_W-1:0]  last_idx;
  logic [ADDR_W-1:0] half_ofs;

  assign adv      = ~hold;
  assign last_idx = (CNT_W'(1) << len_q) - CNT_W'(1);
  assign half_ofs = ADDR_W'(1) << len_q;

  always_comb begin
    if (int'(log_len) > LOG_MAX) begin
      len_clamp = 3'(LOG_MAX);
    end else begin
      len_clamp = log_len;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    cnt_d       = cnt_q;
    rd_vld_d    = rd_vld_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    u_addr_d    = u_addr_q;
    dat_vld_d   = dat_vld_q;
    dat_idx_d   = dat_idx_q;
    wr_vld_d    = wr_vld_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    // All three pipeline stages move in lockstep and only when hold is low.
    // The issue stage empties here; RUN below refills it.
    if (adv) begin
      rd_vld_d  = 1'b0;
      dat_vld_d = rd_vld_q;
      dat_idx_d = u_addr_q;
      wr_vld_d  = dat_vld_q;
      if (dat_vld_q) begin
        wr_data_d = pe_o1;
        wr_addr_d = wr_base_q + dat_idx_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode;
          len_d     = len_clamp;
          rd_base_d = rd_base;
          wr_base_d = wr_base;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (adv) begin
          rd_vld_d    = 1'b1;
          rd_addr_a_d = rd_base_q + ADDR_W'(cnt_q);
          rd_addr_b_d = rd_base_q + ADDR_W'(cnt_q) + half_ofs;
          u_addr_d    = ADDR_W'(cnt_q);
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == last_idx) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Any write still in the write stage is being accepted this cycle.
        if (adv && !rd_vld_q && !dat_vld_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      cnt_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      u_addr_q    <= '0;
      dat_vld_q   <= 1'b0;
      dat_idx_q   <= '0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      rd_base_q   <= rd_base_d;
      wr_base_q   <= wr_base_d;
      cnt_q       <= cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      u_addr_q    <= u_addr_d;
      dat_vld_q   <= dat_vld_d;
      dat_idx_q   <= dat_idx_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Strobes are gated by hold so nothing is issued or written while frozen.
  assign rd_en     = rd_vld_q & ~hold;
  assign wr_en     = wr_vld_q & ~hold;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign u_addr    = u_addr_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign pe_q1     = rd_data_a;
  assign pe_q2     = rd_data_b;
  assign pe_u      = u_data;
  assign pe_mode   = mode_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
